// File: rtl/lsu_byte_sequencer_if.sv
// Request/response channel between the datapath (master) and the byte sequencer (slave).
interface lsu_byte_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 3;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [CTRL_W-1:0] req_ctrl;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_ctrl,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_ctrl,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits one load/store request into single-byte data_memory accesses, one byte per clock,
// and assembles loads with sign/zero extension. Every memory strobe is driven from a flop.
module lsu_byte_sequencer #(
  parameter int unsigned ADDR_W           = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  lsu_byte_sequencer_if.slave bus,
  output logic                mem_we,
  output logic [2:0]          mem_ctrl,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CTRL_W = 3;

  localparam logic [CTRL_W-1:0] CTRL_B    = 3'b000;
  localparam logic [CTRL_W-1:0] CTRL_H    = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_W32  = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_BU   = 3'b100;
  localparam logic [CTRL_W-1:0] CTRL_HU   = 3'b101;
  localparam logic [CTRL_W-1:0] CTRL_BYTE = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q;
  logic                ready_q;
  logic                we_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [CNT_W-1:0]    k_q;
  logic [CNT_W-1:0]    last_k_q;
  logic [DATA_W-1:0]   wsh_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                accept_c;
  logic                illegal_c;
  logic [CNT_W-1:0]    last_k_d;
  logic [DATA_W-1:0]   rbuf_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                unused_mem_rdata;

  assign accept_c         = (state_q == IDLE) && ready_q && bus.req_valid;
  assign unused_mem_rdata = ^mem_rdata[DATA_W-1:BYTE_W];

  // Request decode: byte count and legality, consumed only by registers on accept.
  always_comb begin
    last_k_d  = '0;
    illegal_c = 1'b0;
    case (bus.req_ctrl)
      CTRL_B, CTRL_BU: last_k_d = CNT_W'(0);
      CTRL_H, CTRL_HU: begin
        last_k_d = CNT_W'(1);
        if (!ALLOW_MISALIGNED && bus.req_addr[0]) illegal_c = 1'b1;
      end
      CTRL_W32: begin
        last_k_d = CNT_W'(3);
        if (!ALLOW_MISALIGNED && (bus.req_addr[1:0] != 2'b00)) illegal_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
    if (bus.req_we && bus.req_ctrl[2]) illegal_c = 1'b1;
  end

  // Read bytes shift in from the top, so after N bytes byte0 sits at bit 32-8N.
  always_comb begin
    rbuf_d  = {mem_rdata[BYTE_W-1:0], rbuf_q[DATA_W-1:BYTE_W]};
    rdata_d = '0;
    case (ctrl_q)
      CTRL_B:   rdata_d = {{24{rbuf_d[31]}}, rbuf_d[31:24]};
      CTRL_BU:  rdata_d = {24'h000000, rbuf_d[31:24]};
      CTRL_H:   rdata_d = {{16{rbuf_d[31]}}, rbuf_d[31:16]};
      CTRL_HU:  rdata_d = {16'h0000, rbuf_d[31:16]};
      CTRL_W32: rdata_d = rbuf_d;
      default:  rdata_d = '0;
    endcase
    if (we_q) rdata_d = '0;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      ctrl_q      <= '0;
      k_q         <= '0;
      last_k_q    <= '0;
      wsh_q       <= '0;
      rbuf_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept_c) begin
            ready_q  <= 1'b0;
            we_q     <= bus.req_we;
            ctrl_q   <= bus.req_ctrl;
            k_q      <= '0;
            last_k_q <= last_k_d;
            rbuf_q   <= '0;
            if (illegal_c) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= bus.req_addr;
              mem_wdata_q <= {24'h000000, bus.req_wdata[BYTE_W-1:0]};
              wsh_q       <= {8'h00, bus.req_wdata[DATA_W-1:BYTE_W]};
            end
          end
        end
        ACCESS: begin
          rbuf_q <= rbuf_d;
          if (k_q == last_k_q) begin
            state_q     <= RESP;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
          end else begin
            k_q         <= k_q + CNT_W'(1);
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= {24'h000000, wsh_q[BYTE_W-1:0]};
            wsh_q       <= {8'h00, wsh_q[DATA_W-1:BYTE_W]};
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mem_we        = mem_we_q;
  assign mem_ctrl      = CTRL_BYTE;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: byte-level memory model, per-cycle trace model, literal checks.
module tb_lsu_byte_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  lsu_byte_sequencer_if #(.ADDR_W(32)) b1 ();
  lsu_byte_sequencer_if #(.ADDR_W(32)) b0 ();

  logic        m1_we, m0_we;
  logic [2:0]  m1_ctrl, m0_ctrl;
  logic [31:0] m1_addr, m0_addr, m1_wdata, m0_wdata, m1_rdata, m0_rdata;
  logic [7:0]  mem1 [256];
  logic [7:0]  mem0 [256];
  logic [7:0]  ref_mem [256];
  int          m0_we_cnt = 0;

  lsu_byte_sequencer #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(b1), .mem_we(m1_we), .mem_ctrl(m1_ctrl),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata));

  lsu_byte_sequencer #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_aligned (
    .clk(clk), .rst(rst), .bus(b0), .mem_we(m0_we), .mem_ctrl(m0_ctrl),
    .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata));

  // Byte-wide data memories; upper read bits carry junk the sequencer must ignore.
  assign m1_rdata = {24'hA5C3E1, mem1[m1_addr[7:0]]};
  assign m0_rdata = {24'hA5C3E1, mem0[m0_addr[7:0]]};

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i]    = 8'(i) ^ 8'h5A;
      mem0[i]    = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    forever begin
      @(posedge clk);
      if (m1_we) mem1[m1_addr[7:0]] <= m1_wdata[7:0];
      if (m0_we) mem0[m0_addr[7:0]] <= m0_wdata[7:0];
      if (m0_we) m0_we_cnt <= m0_we_cnt + 1;
    end
  end

  typedef struct packed {
    logic        ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_rdata = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected per-cycle trace of one accepted request; ncommit limits bytes stored to ref_mem.
  function automatic void model_accept(input logic we, input logic [2:0] ctrl,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input int ncommit);
    int          n;
    bit          ill;
    logic [31:0] v;
    logic [31:0] a;
    logic [7:0]  b;
    exp_t        e;
    case (ctrl)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    ill = (n == 0) || (we && ctrl[2]);
    v   = '0;
    if (!ill) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        b = 8'(wdata >> (8 * k));
        e.ready = 1'b0; e.mem_we = we; e.mem_addr = a; e.mem_wdata = {24'h0, b};
        e.rsp_valid = 1'b0; e.rsp_err = 1'b0; e.rsp_rdata = last_rdata;
        exp_q.push_back(e);
        last_addr  = a;
        last_wdata = {24'h0, b};
        if (we) begin
          if (k < ncommit) ref_mem[a[7:0]] = b;
        end else begin
          v = v | (32'(ref_mem[a[7:0]]) << (8 * k));
        end
      end
      if (!we && !ctrl[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    end
    if (ill || we) v = '0;
    e.ready = 1'b0; e.mem_we = 1'b0; e.mem_addr = last_addr; e.mem_wdata = last_wdata;
    e.rsp_valid = 1'b1; e.rsp_err = ill; e.rsp_rdata = v;
    exp_q.push_back(e);
    last_rdata = v;
  endfunction

  // Cycle compare of the main instance against the model, just after each rising edge.
  initial begin
    exp_t e;
    logic rst_s;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        exp_q.delete();
        last_addr = '0; last_wdata = '0; last_rdata = '0;
        e = '0;
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
      end else begin
        e.ready = 1'b1; e.mem_we = 1'b0; e.mem_addr = last_addr; e.mem_wdata = last_wdata;
        e.rsp_valid = 1'b0; e.rsp_err = 1'b0; e.rsp_rdata = last_rdata;
      end
      chk("cyc.req_ready", 32'(b1.req_ready), 32'(e.ready));
      chk("cyc.mem_we", 32'(m1_we), 32'(e.mem_we));
      chk("cyc.mem_addr", m1_addr, e.mem_addr);
      chk("cyc.mem_wdata", m1_wdata, e.mem_wdata);
      chk("cyc.mem_ctrl", 32'(m1_ctrl), 32'd0);
      chk("cyc.rsp_valid", 32'(b1.rsp_valid), 32'(e.rsp_valid));
      if (e.rsp_valid || rst_s) chk("cyc.rsp_err", 32'(b1.rsp_err), 32'(e.rsp_err));
      chk("cyc.rsp_rdata", b1.rsp_rdata, e.rsp_rdata);
    end
  end

  task automatic run(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] lit_rdata,
                     input logic lit_err, input int lit_lat);
    int cyc;
    @(negedge clk);
    b1.req_we = we; b1.req_ctrl = ctrl; b1.req_addr = addr; b1.req_wdata = wdata;
    b1.req_valid = 1'b1;
    cyc = 0;
    while (!b1.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("accept_ready", 32'(b1.req_ready), 32'd1);
    @(posedge clk);
    model_accept(we, ctrl, addr, wdata, 4);
    @(negedge clk);
    b1.req_valid = 1'b0;
    cyc = 1;
    while (!b1.rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rsp_latency", 32'(cyc), 32'(lit_lat));
    chk("rsp_rdata_lit", b1.rsp_rdata, lit_rdata);
    chk("rsp_err_lit", 32'(b1.rsp_err), 32'(lit_err));
    @(negedge clk);
  endtask

  task automatic run0(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] lit_rdata,
                      input logic lit_err, input int lit_lat);
    int cyc;
    int we_before;
    @(negedge clk);
    b0.req_we = we; b0.req_ctrl = ctrl; b0.req_addr = addr; b0.req_wdata = wdata;
    b0.req_valid = 1'b1;
    cyc = 0;
    while (!b0.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("al.accept_ready", 32'(b0.req_ready), 32'd1);
    we_before = m0_we_cnt;
    @(posedge clk);
    @(negedge clk);
    b0.req_valid = 1'b0;
    cyc = 1;
    while (!b0.rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("al.rsp_latency", 32'(cyc), 32'(lit_lat));
    chk("al.rsp_rdata", b0.rsp_rdata, lit_rdata);
    chk("al.rsp_err", 32'(b0.rsp_err), 32'(lit_err));
    chk("al.mem_ctrl", 32'(m0_ctrl), 32'd0);
    if (lit_err) chk("al.err_no_mem_we", 32'(m0_we_cnt - we_before), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_ctrl = '0; b1.req_addr = '0; b1.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_ctrl = '0; b0.req_addr = '0; b0.req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(b1.req_ready), 32'd0);
    chk("rst.mem_we", 32'(m1_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.req_ready", 32'(b1.req_ready), 32'd1);

    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5);
    run(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    run(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    run(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3);
    run(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 3);
    run(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    run(1'b1, 3'b000, 32'h14, 32'h0, 32'h0, 1'b0, 2);
    run(1'b0, 3'b010, 32'h11, 32'h0, 32'h00DEADBE, 1'b0, 5);

    run(1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1'b1, 1);
    run(1'b1, 3'b101, 32'h10, 32'h12345678, 32'h0, 1'b1, 1);
    run(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    run(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    run(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    run(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h5B5AA5A4, 1'b0, 5);
    run(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000CAFE, 32'h0, 1'b0, 3);
    run(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFCAFE, 1'b0, 3);

    // Reset during the second byte of a word store, with a competing request held while busy.
    @(negedge clk);
    b1.req_we = 1'b1; b1.req_ctrl = 3'b010; b1.req_addr = 32'h20; b1.req_wdata = 32'h11223344;
    b1.req_valid = 1'b1;
    chk("rst_seq.ready", 32'(b1.req_ready), 32'd1);
    @(posedge clk);
    model_accept(1'b1, 3'b010, 32'h20, 32'h11223344, 2);
    @(negedge clk);
    b1.req_we = 1'b1; b1.req_ctrl = 3'b000; b1.req_addr = 32'h30; b1.req_wdata = 32'h77;
    chk("busy.req_ready", 32'(b1.req_ready), 32'd0);
    @(negedge clk);
    chk("rst_seq.mem_addr_k1", m1_addr, 32'h21);
    rst = 1'b1;
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq.mem_we", 32'(m1_we), 32'd0);
    chk("rst_seq.rsp_valid", 32'(b1.rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 3'b100, 32'h20, 32'h0, 32'h00000044, 1'b0, 2);
    run(1'b0, 3'b010, 32'h20, 32'h0, 32'h79783344, 1'b0, 5);
    run(1'b0, 3'b100, 32'h30, 32'h0, 32'h0000006A, 1'b0, 2);

    run0(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5);
    run0(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    run0(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    run0(1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1, 1);
    run0(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 3);
    run0(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    run0(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
